// File: rtl/id_ex_pkg.sv
// Shared decoder/pipeline constants and the ID/EX control bundle type.
package id_ex_pkg;

  localparam int unsigned ALUOP_W  = 5;
  localparam int unsigned NPCOP_W  = 3;
  localparam int unsigned WDSEL_W  = 2;
  localparam int unsigned DMTYPE_W = 3;
  localparam int unsigned REG_AW   = 5;

  typedef enum logic [NPCOP_W-1:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JALR   = 3'd3
  } npc_op_e;

  typedef enum logic [WDSEL_W-1:0] {
    WDSEL_FROM_ALU = 2'd0,
    WDSEL_FROM_MEM = 2'd1,
    WDSEL_FROM_PC  = 2'd2
  } wd_sel_e;

  typedef enum logic [DMTYPE_W-1:0] {
    DM_WORD   = 3'd0,
    DM_HALF   = 3'd1,
    DM_HALF_U = 3'd2,
    DM_BYTE   = 3'd3,
    DM_BYTE_U = 3'd4
  } dm_type_e;

  // Control bundle carried from ID into EX
  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                memwrite;
    logic                alusrc;
    logic                itypel;
    logic [ALUOP_W-1:0]  aluop;
    logic [NPCOP_W-1:0]  npcop;
    logic [WDSEL_W-1:0]  wdsel;
    logic [DMTYPE_W-1:0] dmtype;
  } ctrl_t;

  // All-zero bubble: invalid, no writes, npcop = NPC_PLUS4
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector between EX (load) and ID (consumer).
module load_use_detect
  import id_ex_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_itypel_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              lu_c
);

  // Conservative match: rs2 is compared even if the ID instruction ignores it
  always_comb begin
    lu_c = ex_valid_i & ex_itypel_i & (ex_rd_i != '0) & id_valid_i &
           ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// saturating bubble/flush event counters.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                hold_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  logic                id_regwrite_i,
  input  logic                id_memwrite_i,
  input  logic                id_alusrc_i,
  input  logic                id_itypel_i,
  input  logic [ALUOP_W-1:0]  id_aluop_i,
  input  logic [NPCOP_W-1:0]  id_npcop_i,
  input  logic [WDSEL_W-1:0]  id_wdsel_i,
  input  logic [DMTYPE_W-1:0] id_dmtype_i,
  input  logic [XLEN-1:0]     id_pc_i,
  input  logic [XLEN-1:0]     id_rd1_i,
  input  logic [XLEN-1:0]     id_rd2_i,
  input  logic [XLEN-1:0]     id_imm_i,
  input  logic [REG_AW-1:0]   id_rs1_i,
  input  logic [REG_AW-1:0]   id_rs2_i,
  input  logic [REG_AW-1:0]   id_rd_i,
  output logic                ex_valid_o,
  output logic                ex_regwrite_o,
  output logic                ex_memwrite_o,
  output logic                ex_alusrc_o,
  output logic                ex_itypel_o,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic [NPCOP_W-1:0]  ex_npcop_o,
  output logic [WDSEL_W-1:0]  ex_wdsel_o,
  output logic [DMTYPE_W-1:0] ex_dmtype_o,
  output logic [XLEN-1:0]     ex_pc_o,
  output logic [XLEN-1:0]     ex_rd1_o,
  output logic [XLEN-1:0]     ex_rd2_o,
  output logic [XLEN-1:0]     ex_imm_o,
  output logic [REG_AW-1:0]   ex_rs1_o,
  output logic [REG_AW-1:0]   ex_rs2_o,
  output logic [REG_AW-1:0]   ex_rd_o,
  output logic                stall_o,
  output logic [CNT_W-1:0]    bubble_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  ctrl_t              ctrl_q, ctrl_d;
  logic [XLEN-1:0]    pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_AW-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
  logic               lu;

  load_use_detect u_load_use_detect (
    .ex_valid_i  (ctrl_q.valid),
    .ex_itypel_i (ctrl_q.itypel),
    .ex_rd_i     (rd_q),
    .id_valid_i  (id_valid_i),
    .id_rs1_i    (id_rs1_i),
    .id_rs2_i    (id_rs2_i),
    .lu_c        (lu)
  );

  // A flush discards the ID instruction, so its hazard must not stall upstream
  always_comb begin
    stall_o = hold_i | (lu & ~flush_i);
  end

  // Priority: hold > flush > load-use bubble > normal capture
  always_comb begin
    ctrl_d       = ctrl_q;
    pc_d         = pc_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (hold_i) begin
      // keep everything
    end else if (flush_i || lu) begin
      ctrl_d = BUBBLE;
      pc_d   = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      rd_d   = '0;
      if (flush_i) begin
        flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
      end else begin
        bubble_cnt_d = (bubble_cnt_q == '1) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      ctrl_d = '{valid:    id_valid_i,
                 regwrite: id_regwrite_i,
                 memwrite: id_memwrite_i,
                 alusrc:   id_alusrc_i,
                 itypel:   id_itypel_i,
                 aluop:    id_aluop_i,
                 npcop:    id_npcop_i,
                 wdsel:    id_wdsel_i,
                 dmtype:   id_dmtype_i};
      pc_d   = id_pc_i;
      rd1_d  = id_rd1_i;
      rd2_d  = id_rd2_i;
      imm_d  = id_imm_i;
      rs1_d  = id_rs1_i;
      rs2_d  = id_rs2_i;
      rd_d   = id_rd_i;
    end
  end

  // EX register bank and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q       <= BUBBLE;
      pc_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid_o    = ctrl_q.valid;
  assign ex_regwrite_o = ctrl_q.regwrite;
  assign ex_memwrite_o = ctrl_q.memwrite;
  assign ex_alusrc_o   = ctrl_q.alusrc;
  assign ex_itypel_o   = ctrl_q.itypel;
  assign ex_aluop_o    = ctrl_q.aluop;
  assign ex_npcop_o    = ctrl_q.npcop;
  assign ex_wdsel_o    = ctrl_q.wdsel;
  assign ex_dmtype_o   = ctrl_q.dmtype;
  assign ex_pc_o       = pc_q;
  assign ex_rd1_o      = rd1_q;
  assign ex_rd2_o      = rd2_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs1_o      = rs1_q;
  assign ex_rs2_o      = rs2_q;
  assign ex_rd_o       = rd_q;
  assign bubble_cnt_o  = bubble_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed pipeline scenarios followed by
// random traffic, compared against a transaction-level model of the EX slot.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  typedef struct packed {
    logic        valid, regwrite, memwrite, alusrc, itypel;
    logic [4:0]  aluop;
    logic [2:0]  npcop;
    logic [1:0]  wdsel;
    logic [2:0]  dmtype;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
  } slot_t;

  localparam longint unsigned MAX32 = 64'hFFFF_FFFF;
  localparam longint unsigned MAX2  = 64'd3;

  logic  clk, rstn, hold_i, flush_i;
  slot_t cur;

  logic        ex_valid_o, ex_regwrite_o, ex_memwrite_o, ex_alusrc_o, ex_itypel_o;
  logic [4:0]  ex_aluop_o;
  logic [2:0]  ex_npcop_o;
  logic [1:0]  ex_wdsel_o;
  logic [2:0]  ex_dmtype_o;
  logic [31:0] ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic        stall_o;
  logic [31:0] bubble_cnt_o, flush_cnt_o;

  logic        s_valid, s_regwrite, s_memwrite, s_alusrc, s_itypel;
  logic [4:0]  s_aluop;
  logic [2:0]  s_npcop;
  logic [1:0]  s_wdsel;
  logic [2:0]  s_dmtype;
  logic [31:0] s_pc, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_stall;
  logic [1:0]  s_bubble_cnt, s_flush_cnt;

  id_ex_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(cur.valid), .id_regwrite_i(cur.regwrite), .id_memwrite_i(cur.memwrite),
    .id_alusrc_i(cur.alusrc), .id_itypel_i(cur.itypel), .id_aluop_i(cur.aluop),
    .id_npcop_i(cur.npcop), .id_wdsel_i(cur.wdsel), .id_dmtype_i(cur.dmtype),
    .id_pc_i(cur.pc), .id_rd1_i(cur.rd1), .id_rd2_i(cur.rd2), .id_imm_i(cur.imm),
    .id_rs1_i(cur.rs1), .id_rs2_i(cur.rs2), .id_rd_i(cur.rd),
    .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o), .ex_memwrite_o(ex_memwrite_o),
    .ex_alusrc_o(ex_alusrc_o), .ex_itypel_o(ex_itypel_o), .ex_aluop_o(ex_aluop_o),
    .ex_npcop_o(ex_npcop_o), .ex_wdsel_o(ex_wdsel_o), .ex_dmtype_o(ex_dmtype_o),
    .ex_pc_o(ex_pc_o), .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Narrow-counter copy so saturation is reachable in a short run
  id_ex_stage #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .rstn(rstn), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(cur.valid), .id_regwrite_i(cur.regwrite), .id_memwrite_i(cur.memwrite),
    .id_alusrc_i(cur.alusrc), .id_itypel_i(cur.itypel), .id_aluop_i(cur.aluop),
    .id_npcop_i(cur.npcop), .id_wdsel_i(cur.wdsel), .id_dmtype_i(cur.dmtype),
    .id_pc_i(cur.pc), .id_rd1_i(cur.rd1), .id_rd2_i(cur.rd2), .id_imm_i(cur.imm),
    .id_rs1_i(cur.rs1), .id_rs2_i(cur.rs2), .id_rd_i(cur.rd),
    .ex_valid_o(s_valid), .ex_regwrite_o(s_regwrite), .ex_memwrite_o(s_memwrite),
    .ex_alusrc_o(s_alusrc), .ex_itypel_o(s_itypel), .ex_aluop_o(s_aluop),
    .ex_npcop_o(s_npcop), .ex_wdsel_o(s_wdsel), .ex_dmtype_o(s_dmtype),
    .ex_pc_o(s_pc), .ex_rd1_o(s_rd1), .ex_rd2_o(s_rd2), .ex_imm_o(s_imm),
    .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd),
    .stall_o(s_stall), .bubble_cnt_o(s_bubble_cnt), .flush_cnt_o(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents of the EX slot plus raw event counts
  slot_t           m;
  longint unsigned m_bc, m_fc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic model_lu();
    return m.valid && m.itypel && (m.rd != 5'd0) && cur.valid &&
           ((m.rd == cur.rs1) || (m.rd == cur.rs2));
  endfunction

  task automatic model_reset();
    m    = '0;
    m_bc = 0;
    m_fc = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".valid"},    64'(ex_valid_o),    64'(m.valid));
    chk({ph, ".regwrite"}, 64'(ex_regwrite_o), 64'(m.regwrite));
    chk({ph, ".memwrite"}, 64'(ex_memwrite_o), 64'(m.memwrite));
    chk({ph, ".alusrc"},   64'(ex_alusrc_o),   64'(m.alusrc));
    chk({ph, ".itypel"},   64'(ex_itypel_o),   64'(m.itypel));
    chk({ph, ".aluop"},    64'(ex_aluop_o),    64'(m.aluop));
    chk({ph, ".npcop"},    64'(ex_npcop_o),    64'(m.npcop));
    chk({ph, ".wdsel"},    64'(ex_wdsel_o),    64'(m.wdsel));
    chk({ph, ".dmtype"},   64'(ex_dmtype_o),   64'(m.dmtype));
    chk({ph, ".pc"},       64'(ex_pc_o),       64'(m.pc));
    chk({ph, ".rd1"},      64'(ex_rd1_o),      64'(m.rd1));
    chk({ph, ".rd2"},      64'(ex_rd2_o),      64'(m.rd2));
    chk({ph, ".imm"},      64'(ex_imm_o),      64'(m.imm));
    chk({ph, ".rs1"},      64'(ex_rs1_o),      64'(m.rs1));
    chk({ph, ".rs2"},      64'(ex_rs2_o),      64'(m.rs2));
    chk({ph, ".rd"},       64'(ex_rd_o),       64'(m.rd));
    chk({ph, ".bubble_cnt"},   64'(bubble_cnt_o), sat(m_bc, MAX32));
    chk({ph, ".flush_cnt"},    64'(flush_cnt_o),  sat(m_fc, MAX32));
    chk({ph, ".s_bubble_cnt"}, 64'(s_bubble_cnt), sat(m_bc, MAX2));
    chk({ph, ".s_flush_cnt"},  64'(s_flush_cnt),  sat(m_fc, MAX2));
    chk({ph, ".s_valid"},      64'(s_valid),      64'(m.valid));
  endtask

  // One clock: called just after a falling edge with cur already set
  task automatic step(input string ph, input logic h, input logic f);
    logic lu_m;
    hold_i  = h;
    flush_i = f;
    #1;
    lu_m = model_lu();
    chk({ph, ".stall"}, 64'(stall_o), 64'(h | (lu_m & ~f)));
    @(posedge clk);
    if (!h) begin
      if (f) begin
        m = '0;
        m_fc++;
      end else if (lu_m) begin
        m = '0;
        m_bc++;
      end else begin
        m = cur;
      end
    end
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  task automatic set_id(input logic rw, input logic mw, input logic src, input logic ld,
                        input logic [4:0] aluop, input logic [2:0] npc, input logic [1:0] wd,
                        input logic [2:0] dm, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    cur.valid = 1'b1; cur.regwrite = rw; cur.memwrite = mw; cur.alusrc = src;
    cur.itypel = ld; cur.aluop = aluop; cur.npcop = npc; cur.wdsel = wd; cur.dmtype = dm;
    cur.pc = pc; cur.rd1 = a; cur.rd2 = b; cur.imm = imm;
    cur.rs1 = rs1; cur.rs2 = rs2; cur.rd = rd;
  endtask

  task automatic op_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    set_id(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, NPC_PLUS4, WDSEL_FROM_ALU, DM_WORD,
           pc, a, b, 32'd0, rs1, rs2, rd);
  endtask

  task automatic op_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm,
                         input logic [31:0] pc);
    set_id(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, NPC_PLUS4, WDSEL_FROM_ALU, DM_WORD,
           pc, 32'd0, 32'd0, imm, rs1, 5'd0, rd);
  endtask

  task automatic op_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc);
    set_id(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, NPC_PLUS4, WDSEL_FROM_MEM, DM_WORD,
           pc, 32'h100, 32'd0, 32'd0, rs1, 5'd0, rd);
  endtask

  task automatic op_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] pc);
    set_id(1'b0, 1'b1, 1'b1, 1'b0, 5'd1, NPC_PLUS4, WDSEL_FROM_ALU, DM_WORD,
           pc, 32'h100, 32'h55, 32'd0, rs1, rs2, 5'd0);
  endtask

  task automatic rand_id();
    cur.valid    = ($urandom_range(0, 7) != 0);
    cur.regwrite = 1'($urandom);
    cur.memwrite = 1'($urandom);
    cur.alusrc   = 1'($urandom);
    cur.itypel   = ($urandom_range(0, 2) == 0);
    cur.aluop    = 5'($urandom);
    cur.npcop    = 3'($urandom_range(0, 3));
    cur.wdsel    = 2'($urandom_range(0, 2));
    cur.dmtype   = 3'($urandom_range(0, 4));
    cur.pc       = $urandom;
    cur.rd1      = $urandom;
    cur.rd2      = $urandom;
    cur.imm      = $urandom;
    cur.rs1      = 5'($urandom_range(0, 3));
    cur.rs2      = 5'($urandom_range(0, 3));
    cur.rd       = 5'($urandom_range(0, 3));
  endtask

  initial begin
    logic [31:0] pc_save;
    rstn    = 1'b0;
    hold_i  = 1'b0;
    flush_i = 1'b0;
    cur     = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset.stall", 64'(stall_o), 64'd0);
    rstn = 1'b1;

    // Straight-line code
    op_add(5'd3, 5'd1, 5'd2, 32'h0, 32'd5, 32'd7);
    step("add", 1'b0, 1'b0);
    chk("add.pc", 64'(ex_pc_o), 64'h0);
    chk("add.rd1", 64'(ex_rd1_o), 64'd5);
    chk("add.rd2", 64'(ex_rd2_o), 64'd7);
    op_addi(5'd4, 5'd0, 32'd1, 32'h4);
    step("addi", 1'b0, 1'b0);
    chk("addi.rd", 64'(ex_rd_o), 64'd4);
    chk("addi.bubble_cnt", 64'(bubble_cnt_o), 64'd0);

    // Load-use: one bubble, then the consumer enters EX
    op_lw(5'd5, 5'd1, 32'h8);
    step("lw", 1'b0, 1'b0);
    op_add(5'd6, 5'd5, 5'd2, 32'hC, 32'd1, 32'd2);
    #1 chk("lu.stall_hi", 64'(stall_o), 64'd1);
    step("lu_bubble", 1'b0, 1'b0);
    chk("lu.ex_valid", 64'(ex_valid_o), 64'd0);
    chk("lu.ex_regwrite", 64'(ex_regwrite_o), 64'd0);
    chk("lu.bubble_cnt", 64'(bubble_cnt_o), 64'd1);
    #1 chk("lu.stall_lo", 64'(stall_o), 64'd0);
    step("lu_use", 1'b0, 1'b0);
    chk("lu.use_rd", 64'(ex_rd_o), 64'd6);
    chk("lu.use_valid", 64'(ex_valid_o), 64'd1);

    // x0 destination and non-load producer never stall
    op_lw(5'd0, 5'd1, 32'h10);
    step("lw_x0", 1'b0, 1'b0);
    op_add(5'd6, 5'd0, 5'd0, 32'h14, 32'd0, 32'd0);
    #1 chk("x0.stall", 64'(stall_o), 64'd0);
    step("x0_use", 1'b0, 1'b0);
    op_add(5'd5, 5'd1, 5'd2, 32'h18, 32'd3, 32'd4);
    step("add_x5", 1'b0, 1'b0);
    op_add(5'd7, 5'd5, 5'd5, 32'h1C, 32'd3, 32'd4);
    #1 chk("nonload.stall", 64'(stall_o), 64'd0);
    step("nonload_use", 1'b0, 1'b0);

    // Flush beats load-use
    op_lw(5'd5, 5'd1, 32'h20);
    step("lw_f", 1'b0, 1'b0);
    op_sw(5'd5, 5'd1, 32'h24);
    step("flush", 1'b0, 1'b1);
    chk("flush.memwrite", 64'(ex_memwrite_o), 64'd0);
    chk("flush.flush_cnt", 64'(flush_cnt_o), 64'd1);
    chk("flush.bubble_cnt", 64'(bubble_cnt_o), 64'd1);

    // Hold for 3 cycles with a flush pulse in the middle
    op_add(5'd8, 5'd1, 5'd2, 32'h40, 32'd9, 32'd9);
    step("pre_hold", 1'b0, 1'b0);
    pc_save = ex_pc_o;
    step("hold1", 1'b1, 1'b0);
    step("hold2", 1'b1, 1'b1);
    step("hold3", 1'b1, 1'b0);
    chk("hold.pc", 64'(ex_pc_o), 64'(pc_save));
    chk("hold.pc_const", 64'(ex_pc_o), 64'h40);
    chk("hold.flush_cnt", 64'(flush_cnt_o), 64'd1);
    step("hold_reflush", 1'b0, 1'b1);
    chk("reflush.valid", 64'(ex_valid_o), 64'd0);
    chk("reflush.flush_cnt", 64'(flush_cnt_o), 64'd2);

    // Second bubble puts the 2-bit counter one below all-ones
    op_lw(5'd5, 5'd1, 32'h50);
    step("lw2", 1'b0, 1'b0);
    op_add(5'd6, 5'd5, 5'd2, 32'h54, 32'd1, 32'd1);
    step("lu2_bubble", 1'b0, 1'b0);
    step("lu2_use", 1'b0, 1'b0);
    chk("pre_rst.s_bubble_cnt", 64'(s_bubble_cnt), 64'd2);

    // Asynchronous reset in the middle of a load-use stall
    op_lw(5'd5, 5'd1, 32'h60);
    step("lw3", 1'b0, 1'b0);
    op_add(5'd6, 5'd5, 5'd2, 32'h64, 32'd1, 32'd1);
    #1 chk("rst.stall_before", 64'(stall_o), 64'd1);
    #1 rstn = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    chk("rst.stall", 64'(stall_o), 64'd0);
    hold_i = 1'b1;
    #1 chk("rst.stall_hold", 64'(stall_o), 64'd1);
    hold_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step("post_rst", 1'b0, 1'b0);
    chk("post_rst.rd", 64'(ex_rd_o), 64'd6);
    chk("post_rst.bubble_cnt", 64'(bubble_cnt_o), 64'd0);

    // Saturation of the narrow counter
    for (int i = 0; i < 4; i++) begin
      op_lw(5'd5, 5'd1, 32'h70);
      step("sat_lw", 1'b0, 1'b0);
      op_add(5'd6, 5'd5, 5'd2, 32'h74, 32'd1, 32'd1);
      step("sat_bubble", 1'b0, 1'b0);
      step("sat_use", 1'b0, 1'b0);
    end
    chk("sat.s_bubble_cnt", 64'(s_bubble_cnt), 64'd3);
    chk("sat.bubble_cnt", 64'(bubble_cnt_o), 64'd4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with built-in load-use hazard detection, bubble insertion and branch flush. It sits directly downstream of the instruction decoder. It captures the decoder's control bundle together with the ID-stage operands, and presents them to the execute stage one cycle later. It also drives the stall back to the PC and IF/ID registers.

## Interface
- `XLEN`, 32: data/PC width
- `CNT_W`, 32: width of each performance counter
- `clk` in 1: rising-edge clock
- `rstn` in 1: asynchronous, active-low reset
- `hold_i` in 1: downstream (MEM) freeze; EX register keeps its contents
- `flush_i` in 1: branch/jump resolved taken in EX; kill the instruction currently in ID
- `id_valid_i` in 1: ID slot holds a real instruction
- `id_regwrite_i` in 1, `id_memwrite_i` in 1, `id_alusrc_i` in 1, `id_itypel_i` in 1: decoder control bits
- `id_aluop_i` in 5, `id_npcop_i` in 3, `id_wdsel_i` in 2, `id_dmtype_i` in 3: decoder control fields
- `id_pc_i` in XLEN, `id_rd1_i` in XLEN, `id_rd2_i` in XLEN, `id_imm_i` in XLEN: operands and extended immediate
- `id_rs1_i` in 5, `id_rs2_i` in 5, `id_rd_i` in 5: register addresses
- `ex_*_o` out (same widths): registered copies of every `id_*_i` above, plus `ex_valid_o`
- `stall_o` out 1: freeze PC and IF/ID this cycle
- `bubble_cnt_o` out CNT_W: load-use bubbles inserted
- `flush_cnt_o` out CNT_W: flushes applied

## Operation
- **Load-use hazard (combinational).** `lu = ex_valid_o & ex_itypel_o & ex_rd_o!=0 & id_valid_i & (ex_rd_o==id_rs1_i | ex_rd_o==id_rs2_i)`.
  - The comparison is conservative and ignores whether the instruction actually reads rs2.
- **Stall output.** `stall_o = hold_i | (lu & ~flush_i)`.
- **Per-cycle update**, priority highest first:
  1. `hold_i`: all `ex_*` registers keep their values. No counter changes.
  2. `flush_i`: load a bubble and increment `flush_cnt_o`.
  3. `lu`: load a bubble and increment `bubble_cnt_o`.
  4. Otherwise: capture all `id_*` inputs, with `ex_valid_o <= id_valid_i`.
- **Bubble contents.** Every `ex_*` output is 0, including `ex_valid_o`, `ex_regwrite_o`, `ex_memwrite_o` and `ex_npcop_o` (NPC_PLUS4). A bubble can never write the register file or memory, and can never redirect the PC.
- **hold_i and flush_i together.** Hold wins. The branch stays in EX, and the flush source must re-assert `flush_i` on the first cycle without `hold_i`.
- **flush_i and lu together.** Flush wins. The ID instruction is discarded anyway, so `stall_o` is not raised for `lu`.
- **Counters.** Saturate at all-ones. They are not cleared by flush.
- **Forwarding.** Not done here; forwarding from MEM/WB is handled elsewhere. This block guarantees only the single load-use bubble.

## Timing
- **Latency.** One cycle, ID input to EX output, when neither hold nor a hazard is active.
- **Load-use penalty.** Exactly one cycle. The cycle after the bubble, `ex_valid_o = 0`, so `lu` drops and the held ID instruction is captured.
- **Stall visibility.** `stall_o` is combinational in the same cycle as the hazard. Upstream registers sample it at the same edge at which the bubble is loaded.
- **Reset.**
  - `rstn` low forces all `ex_*` outputs and both counters to 0 immediately; asynchronous assertion.
  - `stall_o` then reflects only `hold_i`.
  - Release is synchronous to `clk` upstream of this block.
  - Reset mid-stall discards the held state; the first post-reset edge captures ID normally.
- **Combinational paths.** No path from `id_*` inputs to `ex_*` outputs.

## Structure
- **Shared package** (the same one the decoder constants use):
  - NPC_PLUS4/BRANCH/JUMP/JALR codes
  - WDSel_FromALU/MEM/PC codes
  - DMType codes
  - the ALUOp width
  - a `BUBBLE` all-zero constant for the control bundle
- **Sub-module `load_use_detect`.** Purely combinational. Inputs are `ex_valid`, `ex_itypel`, `ex_rd`, `id_valid`, `id_rs1` and `id_rs2`; output is `lu`. It is reused by the future multi-cycle-MEM variant.
- **Top level.** The remaining register bank, priority mux and two saturating counters stay in `id_ex_stage`.

## Test plan
- **Straight-line code.** `add x3,x1,x2` at pc 0x0 with `id_rd1_i = 5`, `id_rd2_i = 7`, followed by `addi x4,x0,1`.
  - Required: the EX outputs mirror ID one cycle later, with `ex_pc_o = 0x0`, `ex_rd1_o = 5`, `ex_rd2_o = 7`.
  - Required: `stall_o = 0` and both counters stay 0.
- **Load-use.** `lw x5,0(x1)` followed by `add x6,x5,x2`.
  - Required: `stall_o = 1` for exactly one cycle, and one bubble appears in EX (`ex_valid_o = 0`, `ex_regwrite_o = 0`).
  - Required: the `add` enters EX on the next cycle and `bubble_cnt_o = 1`.
- **x0 and non-load cases.**
  - `lw x0,...` followed by `add x6,x0,x0` must not stall.
  - An `add x5,...` followed by a use of x5 must not stall.
- **Flush.** `flush_i = 1` while ID holds a valid `sw` with `lu` also true.
  - Required: a bubble is loaded, `ex_memwrite_o = 0`, `stall_o = 0`, `flush_cnt_o` increments and `bubble_cnt_o` does not.
- **Hold.** `hold_i = 1` for 3 cycles with `flush_i` pulsed in cycle 2.
  - Required: the EX outputs are unchanged throughout, `stall_o = 1`, and no counter moves.
  - Required: when `flush_i` is re-asserted after the hold, a bubble is loaded.
- **Reset mid-operation.** Drop `rstn` during a load-use stall with `bubble_cnt_o = 0xFFFFFFFE`.
  - Required: all outputs go to 0 asynchronously.
  - Separately: driving two further bubbles from 0xFFFFFFFE must saturate the counter at 0xFFFFFFFF.
